pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Controller that sequences a programmable serial pattern detector over a bounded window of the serial input `w`. A host loads a pattern and a window length, then pulses `start`. The block consumes `cfg_len` valid bits, counts pattern matches, and reports completion with a `done` pulse and a held match count. It sits between the host/config logic and the serial bit stream, replacing hard-wired fixed-pattern Moore detectors.

Parameters:
PAT_W, 4, pattern width in bits (2..16)
LEN_W, 8, width of window length / remaining-bit counter
CNT_W, 8, width of match counter

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  begin scan; sampled only in IDLE
cfg_pattern  input  PAT_W  pattern; MSB is compared with the earliest received bit
cfg_len  input  LEN_W  number of valid bits to scan
w  input  1  serial data bit
w_valid  input  1  `w` is consumed this cycle when high in SCAN
busy  output  1  high in SCAN
z  output  1  registered match pulse
done  output  1  one-cycle completion pulse
match_count  output  CNT_W  matches in last/current scan

Behaviour:
- One clock (`Clock`). Reset is synchronous and active-high (`Reset`).
- Reset values: state IDLE; busy=0, z=0, done=0, match_count=0; history, fill and remaining counters = 0.
- Reset asserted mid-scan aborts the scan: all values return to reset values at that edge, and no done pulse is produced.
- States (Moore FSM; all outputs are registered or decoded from state only):
  - IDLE: start=1 and cfg_len!=0 → latch cfg_pattern and cfg_len, clear match_count, history and fill; next state SCAN.
  - IDLE: start=1 and cfg_len==0 → clear match_count; next state DONE.
  - SCAN, w_valid=0 → no change; stall for any number of cycles.
  - SCAN, w_valid=1 → consume the bit:
    - shift it into history (LSB side);
    - fill saturates at PAT_W;
    - remaining decrements;
    - if this was the last bit (remaining==1), next state DONE.
  - DONE: done=1 for exactly one cycle; next state IDLE.
- start is ignored in SCAN and DONE. cfg_* changes after latching have no effect.
- Match condition: a bit is consumed, fill (including this bit) ≥ PAT_W, and the new history equals the latched pattern.
- On a match:
  - z=1 in the cycle after the matching bit is accepted, for one cycle;
  - match_count increments at the same edge.
- match_count saturates at 2^CNT_W−1 and does not wrap.
- Latency: bit accepted at edge k → z/match_count visible after edge k. If the last bit matches, z and done are both high in the DONE cycle.
- match_count holds its value in IDLE until the next accepted start.
- Window shorter than PAT_W: no match is possible and done still fires.

Optional Feature:
PATTERN_SCAN_OVERLAP_EN
- Defined: overlapping matches are counted; history is kept after a match.
- Undefined: non-overlapping; history and fill clear at a match, so the next match needs PAT_W fresh bits.

Decomposition:
- Package seq_ctrl_pkg:
  - state encoding IDLE=2'b00, SCAN=2'b01, DONE=2'b10; 2'b11 recovers to IDLE;
  - default width constants.
- Sub-module pattern_matcher (history shift register, fill counter, compare; inputs shift/clear/pattern, output hit). The FSM, counters and outputs stay in pattern_scan_ctrl.

Test Plan:
- Reset check: assert Reset for 2 cycles mid-scan → busy=0, done=0, z=0, match_count=0; no done pulse afterwards.
- Basic window: pattern 4'b1101, len 4, stream 1,1,0,1 → z after 4th bit; done in the same cycle; match_count=1.
- Overlap: pattern 1101, len 7, stream 1101101 → match_count=2 with PATTERN_SCAN_OVERLAP_EN, 1 without.
- Stall: len 4 with w_valid low for 3 cycles between bits → same result as the unstalled case; busy stays high throughout; done only after the 4th valid bit.
- Edge lengths:
  - len 0 → done the cycle after start; match_count=0.
  - len 3 with pattern 1101 → done, match_count=0.
- Saturation and ignored start: CNT_W=2, pattern 4'b1111, len 20 of all 1s with overlap → match_count=3; start pulses during SCAN ignored.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared state encoding and default widths for the pattern scan controller.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/pattern_matcher.sv
// History shift register, fill counter and pattern compare for the scan controller.
// PATTERN_SCAN_OVERLAP_EN keeps history after a hit; otherwise a hit restarts the fill.
module pattern_matcher
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             data_bit,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  history_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;

    // The fill check stops the all-zero reset history from matching a zero pattern.
    always_comb begin
        history_next = {history[PAT_W-2:0], data_bit};
        fill_next    = (fill == FULL) ? FULL : fill + FILL_W'(1);
        hit          = shift && (fill_next == FULL) && (history_next == pattern);
    end

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
`ifdef PATTERN_SCAN_OVERLAP_EN
            history <= history_next;
            fill    <= fill_next;
`else
            if (hit) begin
                history <= '0;
                fill    <= '0;
            end else begin
                history <= history_next;
                fill    <= fill_next;
            end
`endif
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequences a programmable serial pattern detector over a window of cfg_len valid bits.
// Optional PATTERN_SCAN_OVERLAP_EN (in pattern_matcher) counts overlapping matches.
module pattern_scan_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             w,
    input  logic             w_valid,
    output logic             busy,
    output logic             z,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       dbg_state
);

    state_t           state;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] remaining;
    logic             clear;
    logic             shift;
    logic             hit;

    assign dbg_state = state;
    assign clear     = (state == ST_IDLE) && start && (cfg_len != '0);
    assign shift     = (state == ST_SCAN) && w_valid;

    pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (clear),
        .shift    (shift),
        .data_bit (w),
        .pattern  (pattern_q),
        .hit      (hit)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            z           <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            remaining   <= '0;
            pattern_q   <= '0;
        end else begin
            z    <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        match_count <= '0;
                        if (cfg_len != '0) begin
                            pattern_q <= cfg_pattern;
                            remaining <= cfg_len;
                            busy      <= 1'b1;
                            state     <= ST_SCAN;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_valid) begin
                        remaining <= remaining - LEN_W'(1);
                        if (hit) begin
                            z <= 1'b1;
                            // Saturate rather than wrap so a large count stays meaningful.
                            if (match_count != {CNT_W{1'b1}})
                                match_count <= match_count + CNT_W'(1);
                        end
                        if (remaining == LEN_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: driver pushes expected scan results, monitor checks on done.
module tb_pattern_scan_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start;
    logic [3:0] cfg_pattern;
    logic [7:0] cfg_len;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       z;
    logic       done;
    logic [7:0] match_count;
    logic [1:0] dbg_state;

    logic       s_start;
    logic [3:0] s_cfg_pattern;
    logic [7:0] s_cfg_len;
    logic       s_w;
    logic       s_w_valid;
    logic       s_busy;
    logic       s_z;
    logic       s_done;
    logic [1:0] s_match_count;
    logic [1:0] s_dbg_state;

    int checks   = 0;
    int failures = 0;
    int z_seen   = 0;
    // Each entry: {z high at done, z pulses during scan, match_count at done}
    logic [16:0] exp_q[$];

    always #5 Clock = ~Clock;

    pattern_scan_ctrl dut (
        .Clock(Clock), .Reset(Reset), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .w(w), .w_valid(w_valid), .busy(busy), .z(z),
        .done(done), .match_count(match_count), .dbg_state(dbg_state)
    );

    pattern_scan_ctrl #(.CNT_W(2)) dut_sat (
        .Clock(Clock), .Reset(Reset), .start(s_start), .cfg_pattern(s_cfg_pattern),
        .cfg_len(s_cfg_len), .w(s_w), .w_valid(s_w_valid), .busy(s_busy), .z(s_z),
        .done(s_done), .match_count(s_match_count), .dbg_state(s_dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin : monitor
        logic [16:0] e;
        if (Reset) begin
            z_seen = 0;
        end else begin
            if (z) z_seen++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("match_count", match_count, e[7:0]);
                    check("z_at_done", z, e[16]);
                    check("z_pulses", z_seen, e[15:8]);
                end
                z_seen = 0;
            end
        end
    end

    task automatic run_scan(input logic [3:0] pat, input logic [7:0] len, input logic [31:0] bits,
                            input int nbits, input int stall, input logic zd,
                            input logic [7:0] zp, input logic [7:0] cnt);
        exp_q.push_back({zd, zp, cnt});
        cfg_pattern = pat;
        cfg_len     = len;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        cfg_pattern = ~pat;
        cfg_len     = 8'hff;
        for (int i = 0; i < nbits; i++) begin
            w       = bits[nbits-1-i];
            w_valid = 1'b1;
            tick();
            w_valid = 1'b0;
            if (i < nbits - 1) begin
                for (int s = 0; s < stall; s++) begin
                    w = 1'($urandom_range(0, 1));
                    tick();
                    check("busy_stall", busy, 1);
                    check("done_early", done, 0);
                end
            end
        end
        tick();
        tick();
    endtask

    initial begin : driver
        int zc;
        Reset = 1'b1; start = 1'b0; cfg_pattern = '0; cfg_len = '0; w = 1'b0; w_valid = 1'b0;
        s_start = 1'b0; s_cfg_pattern = '0; s_cfg_len = '0; s_w = 1'b0; s_w_valid = 1'b0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_z", z, 0);
        check("rst_done", done, 0);
        check("rst_count", match_count, 0);
        check("rst_state", dbg_state, 0);
        Reset = 1'b0;
        tick();

        run_scan(4'b1101, 8'd4, 32'b1101, 4, 0, 1'b1, 8'd1, 8'd1);
        repeat (3) tick();
        check("count_hold", match_count, 1);
`ifdef PATTERN_SCAN_OVERLAP_EN
        run_scan(4'b1101, 8'd7, 32'b1101101, 7, 0, 1'b1, 8'd2, 8'd2);
        run_scan(4'b1010, 8'd8, 32'b10101010, 8, 0, 1'b1, 8'd3, 8'd3);
`else
        run_scan(4'b1101, 8'd7, 32'b1101101, 7, 0, 1'b0, 8'd1, 8'd1);
        run_scan(4'b1010, 8'd8, 32'b10101010, 8, 0, 1'b1, 8'd2, 8'd2);
`endif
        run_scan(4'b1101, 8'd4, 32'b1101, 4, 3, 1'b1, 8'd1, 8'd1);
        run_scan(4'b1101, 8'd0, 32'b0, 0, 0, 1'b0, 8'd0, 8'd0);
        run_scan(4'b1101, 8'd3, 32'b110, 3, 0, 1'b0, 8'd0, 8'd0);
        run_scan(4'b0000, 8'd3, 32'b000, 3, 0, 1'b0, 8'd0, 8'd0);
        run_scan(4'b0000, 8'd4, 32'b0000, 4, 0, 1'b1, 8'd1, 8'd1);
        run_scan(4'b1101, 8'd6, 32'b011010, 6, 1, 1'b0, 8'd1, 8'd1);

        // Abort a scan with Reset after one match has been counted.
        cfg_pattern = 4'b1101; cfg_len = 8'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = (i == 2) ? 1'b0 : 1'b1;
            w_valid = 1'b1;
            tick();
        end
        w_valid = 1'b0;
        check("abort_pre_count", match_count, 1);
        Reset = 1'b1;
        repeat (2) tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_z", z, 0);
        check("abort_count", match_count, 0);
        check("abort_state", dbg_state, 0);
        Reset = 1'b0;
        repeat (5) tick();
        check("abort_idle_busy", busy, 0);

        // Saturating 2-bit counter with start pulses during the scan.
        s_cfg_pattern = 4'b1111; s_cfg_len = 8'd20; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        zc = 0;
        for (int i = 0; i < 20; i++) begin
            s_w = 1'b1;
            s_w_valid = 1'b1;
            s_start = (i % 5 == 2);
            tick();
            if (s_z) zc++;
            if (i < 19) check("sat_done_early", s_done, 0);
        end
        s_w_valid = 1'b0;
        s_start = 1'b0;
        check("sat_done", s_done, 1);
        check("sat_count", s_match_count, 2'b11);
`ifdef PATTERN_SCAN_OVERLAP_EN
        check("sat_z_pulses", zc, 17);
`else
        check("sat_z_pulses", zc, 5);
`endif
        tick();
        check("sat_idle_busy", s_busy, 0);
        check("sat_idle_state", s_dbg_state, 0);
        check("sat_hold", s_match_count, 2'b11);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
